p405s_dcu_fill_buf_ctl: RTL and testbench

Line-fill buffer for the DCU. It captures a cache line delivered critical-doubleword-first over the 64-bit PLB read bus and merges SDQ store bytes that hit the line while it is filling. It drives the eight fillBufWord*_L2 registers and the word/byte select signals consumed by the fill-buffer bypass mux. When the line is complete it handshakes a single write into the data array.

---
 rtl/p405s_dcu_fill_pkg.sv | 19 +
 rtl/p405s_dcu_fill_word_reg.sv | 58 +++++
 rtl/p405s_dcu_fill_buf_ctl.sv | 173 +++++++++++++++++
 tb/tb_p405s_dcu_fill_buf_ctl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/p405s_dcu_fill_pkg.sv
// Shared constants and state encoding for the DCU line-fill buffer.
// Line geometry is fixed at four 64-bit doublewords (eight 32-bit words).
package p405s_dcu_fill_pkg;

    localparam int LINE_DW    = 4;
    localparam int DW_W       = 64;
    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 2 * LINE_DW;
    localparam int CNT_W      = $clog2(LINE_DW);
    localparam int WADDR_W    = $clog2(LINE_WORDS);
    localparam int BYTES_W    = WORD_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_WRITE = 2'b10
    } fill_state_e;

endpackage

// File: rtl/p405s_dcu_fill_word_reg.sv
// One fill-buffer word: byte-granular store merge with a per-byte mask that
// protects store bytes from being overwritten by the later PLB beat.
module p405s_dcu_fill_word_reg
    import p405s_dcu_fill_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               i_clr,
    input  logic               i_beat_we,
    input  logic [WORD_W-1:0]  i_beat_data,
    input  logic               i_st_we,
    input  logic [BYTES_W-1:0] i_st_be,
    input  logic [WORD_W-1:0]  i_st_data,
    output logic [WORD_W-1:0]  o_word,
    output logic               o_valid
);

    logic [WORD_W-1:0]  r_word;
    logic [WORD_W-1:0]  w_word_next;
    logic [BYTES_W-1:0] r_mask;
    logic [BYTES_W-1:0] w_mask_next;
    logic [BYTES_W-1:0] w_st_hit;
    logic               r_valid;

    // A store byte always wins; the beat only fills bytes no store has claimed.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_W; gi++) begin : g_byte
            assign w_st_hit[gi] = i_st_we & i_st_be[gi];
            assign w_word_next[gi*8 +: 8] =
                w_st_hit[gi]                  ? i_st_data[gi*8 +: 8]   :
                (i_beat_we & ~r_mask[gi])     ? i_beat_data[gi*8 +: 8] :
                                                r_word[gi*8 +: 8];
            assign w_mask_next[gi] = r_mask[gi] | w_st_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            r_word  <= '0;
            r_mask  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_word <= w_word_next;
            if (i_clr) begin
                r_mask  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_mask  <= w_mask_next;
                r_valid <= r_valid | i_beat_we;
            end
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;

endmodule

// File: rtl/p405s_dcu_fill_buf_ctl.sv
// DCU line-fill buffer: captures a critical-doubleword-first PLB line, merges
// SDQ stores while filling, forwards to loads and hands the line to the array.
module p405s_dcu_fill_buf_ctl
    import p405s_dcu_fill_pkg::*;
(
    input  logic                CB,
    input  logic                reset,
    input  logic                fillStart,
    input  logic [CNT_W-1:0]    fillStartDw,
    input  logic                plbRdDAck,
    input  logic [DW_W-1:0]     plbRdData,
    input  logic                plbRdErr,
    input  logic                storeValid,
    input  logic [WADDR_W-1:0]  storeWordAddr,
    input  logic [BYTES_W-1:0]  storeByteEn,
    input  logic [WORD_W-1:0]   SDQ_mux,
    input  logic                loadReq,
    input  logic [WADDR_W-1:0]  loadWordAddr,
    input  logic                arrayWrAck,
    output logic [WORD_W-1:0]   fillBufWord0_L2,
    output logic [WORD_W-1:0]   fillBufWord1_L2,
    output logic [WORD_W-1:0]   fillBufWord2_L2,
    output logic [WORD_W-1:0]   fillBufWord3_L2,
    output logic [WORD_W-1:0]   fillBufWord4_L2,
    output logic [WORD_W-1:0]   fillBufWord5_L2,
    output logic [WORD_W-1:0]   fillBufWord6_L2,
    output logic [WORD_W-1:0]   fillBufWord7_L2,
    output logic [LINE_WORDS-1:0] fillBufWordValid,
    output logic [WADDR_W-1:0]  bypassMuxSel,
    output logic [BYTES_W-1:0]  bypassFillSDP_sel,
    output logic                loadHit,
    output logic                fillBusy,
    output logic                storeStall,
    output logic                arrayWrReq,
    output logic                fillDone,
    output logic                fillErr
);

    fill_state_e        r_state;
    fill_state_e        w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_start_dw;
    logic               r_err;
    logic               r_wr_req;
    logic               r_done;
    logic               r_fill_err;
    logic               w_wr_req_next;
    logic               w_done_next;
    logic               w_fill_err_next;
    logic               w_clr;
    logic               w_in_fill;
    logic               w_beat;
    logic               w_last_beat;
    logic [CNT_W-1:0]   w_dw;
    logic [WORD_W-1:0]  w_word [LINE_WORDS];
    logic [LINE_WORDS-1:0] w_valid;

    assign w_in_fill   = (r_state == ST_FILL);
    assign w_beat      = w_in_fill & plbRdDAck;
    assign w_dw        = r_start_dw + r_cnt;
    assign w_last_beat = w_beat & (r_cnt == CNT_W'(LINE_DW - 1));

    always_comb begin
        w_state_next    = r_state;
        w_wr_req_next   = 1'b0;
        w_done_next     = 1'b0;
        w_fill_err_next = 1'b0;
        w_clr           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fillStart) begin
                    w_state_next = ST_FILL;
                    w_clr        = 1'b1;
                end
            end
            ST_FILL: begin
                if (w_last_beat) begin
                    if (r_err | plbRdErr) begin
                        w_state_next    = ST_IDLE;
                        w_fill_err_next = 1'b1;
                        w_clr           = 1'b1;
                    end else begin
                        w_state_next  = ST_WRITE;
                        w_wr_req_next = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (arrayWrAck) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                    w_clr        = 1'b1;
                end else begin
                    w_wr_req_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CB) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_start_dw <= '0;
            r_err      <= 1'b0;
            r_wr_req   <= 1'b0;
            r_done     <= 1'b0;
            r_fill_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_req   <= w_wr_req_next;
            r_done     <= w_done_next;
            r_fill_err <= w_fill_err_next;
            if ((r_state == ST_IDLE) && fillStart) begin
                r_start_dw <= fillStartDw;
                r_cnt      <= '0;
                r_err      <= 1'b0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_err <= r_err | plbRdErr;
            end
        end
    end

    // Beat k carries words 2k (upper half) and 2k+1 (lower half).
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] w_beat_half;
            if (gi % 2 == 0) begin : g_even
                assign w_beat_half = plbRdData[DW_W-1 -: WORD_W];
            end else begin : g_odd
                assign w_beat_half = plbRdData[WORD_W-1:0];
            end

            p405s_dcu_fill_word_reg u_word (
                .clk         (CB),
                .srst        (reset),
                .i_clr       (w_clr),
                .i_beat_we   (w_beat & (w_dw == CNT_W'(gi / 2))),
                .i_beat_data (w_beat_half),
                .i_st_we     (w_in_fill & storeValid & (storeWordAddr == WADDR_W'(gi))),
                .i_st_be     (storeByteEn),
                .i_st_data   (SDQ_mux),
                .o_word      (w_word[gi]),
                .o_valid     (w_valid[gi])
            );
        end
    endgenerate

    assign fillBufWord0_L2  = w_word[0];
    assign fillBufWord1_L2  = w_word[1];
    assign fillBufWord2_L2  = w_word[2];
    assign fillBufWord3_L2  = w_word[3];
    assign fillBufWord4_L2  = w_word[4];
    assign fillBufWord5_L2  = w_word[5];
    assign fillBufWord6_L2  = w_word[6];
    assign fillBufWord7_L2  = w_word[7];
    assign fillBufWordValid = w_valid;

    assign bypassMuxSel      = loadWordAddr;
    assign bypassFillSDP_sel = {BYTES_W{loadReq & storeValid & w_in_fill &
                                        (storeWordAddr == loadWordAddr)}} & storeByteEn;
    assign loadHit    = loadReq & (r_state != ST_IDLE) &
                        (w_valid[loadWordAddr] | (&bypassFillSDP_sel));
    assign fillBusy   = (r_state != ST_IDLE);
    assign storeStall = storeValid & (r_state == ST_WRITE);
    assign arrayWrReq = r_wr_req;
    assign fillDone   = r_done;
    assign fillErr    = r_fill_err;

endmodule

// File: tb/tb_p405s_dcu_fill_buf_ctl.sv
// Directed self-checking bench for the DCU line-fill buffer.
module tb_p405s_dcu_fill_buf_ctl;

    logic        CB = 1'b0;
    logic        reset;
    logic        fillStart;
    logic [1:0]  fillStartDw;
    logic        plbRdDAck;
    logic [63:0] plbRdData;
    logic        plbRdErr;
    logic        storeValid;
    logic [2:0]  storeWordAddr;
    logic [3:0]  storeByteEn;
    logic [31:0] SDQ_mux;
    logic        loadReq;
    logic [2:0]  loadWordAddr;
    logic        arrayWrAck;
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [7:0]  fillBufWordValid;
    logic [2:0]  bypassMuxSel;
    logic [3:0]  bypassFillSDP_sel;
    logic        loadHit, fillBusy, storeStall, arrayWrReq, fillDone, fillErr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CB = ~CB;

    p405s_dcu_fill_buf_ctl dut (
        .CB(CB), .reset(reset), .fillStart(fillStart), .fillStartDw(fillStartDw),
        .plbRdDAck(plbRdDAck), .plbRdData(plbRdData), .plbRdErr(plbRdErr),
        .storeValid(storeValid), .storeWordAddr(storeWordAddr), .storeByteEn(storeByteEn),
        .SDQ_mux(SDQ_mux), .loadReq(loadReq), .loadWordAddr(loadWordAddr),
        .arrayWrAck(arrayWrAck),
        .fillBufWord0_L2(w0), .fillBufWord1_L2(w1), .fillBufWord2_L2(w2), .fillBufWord3_L2(w3),
        .fillBufWord4_L2(w4), .fillBufWord5_L2(w5), .fillBufWord6_L2(w6), .fillBufWord7_L2(w7),
        .fillBufWordValid(fillBufWordValid), .bypassMuxSel(bypassMuxSel),
        .bypassFillSDP_sel(bypassFillSDP_sel), .loadHit(loadHit), .fillBusy(fillBusy),
        .storeStall(storeStall), .arrayWrReq(arrayWrReq), .fillDone(fillDone), .fillErr(fillErr)
    );

    task automatic step();
        @(posedge CB);
        #1;
    endtask

    task automatic start_fill(input logic [1:0] dw);
        fillStart   = 1'b1;
        fillStartDw = dw;
        step();
        fillStart   = 1'b0;
    endtask

    task automatic beat(input logic [63:0] data, input logic err);
        plbRdDAck = 1'b1;
        plbRdData = data;
        plbRdErr  = err;
        step();
        plbRdDAck = 1'b0;
        plbRdErr  = 1'b0;
    endtask

    task automatic ack_line();
        arrayWrAck = 1'b1;
        step();
        arrayWrAck = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (fillBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", fillBusy); end
        n_cmp++; if (fillBufWordValid !== 8'h00) begin n_bad++; $display("FAIL reset_valid got=%h exp=00", fillBufWordValid); end
        n_cmp++; if ({arrayWrReq, fillDone, fillErr} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got=%b exp=000", {arrayWrReq, fillDone, fillErr}); end
        n_cmp++; if (w0 !== 32'h0) begin n_bad++; $display("FAIL reset_word0 got=%h exp=00000000", w0); end
        $display("test_reset done");
    endtask

    task automatic test_fill_order();
        logic [7:0] exp_v [4];
        exp_v = '{8'h30, 8'hF0, 8'hF3, 8'hFF};
        start_fill(2'd2);
        n_cmp++; if (fillBusy !== 1'b1) begin n_bad++; $display("FAIL order_busy got=%b exp=1", fillBusy); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (arrayWrReq !== 1'b0) begin n_bad++; $display("FAIL order_wrreq_early k=%0d got=%b exp=0", k, arrayWrReq); end
            beat({32'(32'h1000 + k), 32'(32'h2000 + k)}, 1'b0);
            n_cmp++; if (fillBufWordValid !== exp_v[k]) begin n_bad++; $display("FAIL order_valid k=%0d got=%h exp=%h", k, fillBufWordValid, exp_v[k]); end
        end
        n_cmp++; if (arrayWrReq !== 1'b1) begin n_bad++; $display("FAIL order_wrreq got=%b exp=1", arrayWrReq); end
        n_cmp++; if (w4 !== 32'h1000) begin n_bad++; $display("FAIL order_word4 got=%h exp=00001000", w4); end
        n_cmp++; if (w5 !== 32'h2000) begin n_bad++; $display("FAIL order_word5 got=%h exp=00002000", w5); end
        n_cmp++; if (w7 !== 32'h2001) begin n_bad++; $display("FAIL order_word7 got=%h exp=00002001", w7); end
        n_cmp++; if (w0 !== 32'h1002) begin n_bad++; $display("FAIL order_word0 got=%h exp=00001002", w0); end
        n_cmp++; if (w3 !== 32'h2003) begin n_bad++; $display("FAIL order_word3 got=%h exp=00002003", w3); end
        ack_line();
        n_cmp++; if ({fillDone, arrayWrReq, fillBusy} !== 3'b100) begin n_bad++; $display("FAIL order_done got=%b exp=100", {fillDone, arrayWrReq, fillBusy}); end
        n_cmp++; if (fillBufWordValid !== 8'h00) begin n_bad++; $display("FAIL order_valid_clr got=%h exp=00", fillBufWordValid); end
        step();
        n_cmp++; if (fillDone !== 1'b0) begin n_bad++; $display("FAIL order_done_pulse got=%b exp=0", fillDone); end
        $display("test_fill_order done");
    endtask

    task automatic test_store_merge();
        start_fill(2'd0);
        storeValid = 1'b1; storeWordAddr = 3'd1; storeByteEn = 4'b1000; SDQ_mux = 32'hAB000000;
        step();
        storeValid = 1'b0;
        n_cmp++; if (w1[31:24] !== 8'hAB) begin n_bad++; $display("FAIL merge_store_byte got=%h exp=ab", w1[31:24]); end
        beat({32'h55667788, 32'h11223344}, 1'b0);
        n_cmp++; if (w1 !== 32'hAB223344) begin n_bad++; $display("FAIL merge_word1 got=%h exp=ab223344", w1); end
        n_cmp++; if (w0 !== 32'h55667788) begin n_bad++; $display("FAIL merge_word0 got=%h exp=55667788", w0); end
        for (int k = 1; k < 4; k++) beat(64'h0, 1'b0);
        ack_line();
        step();
        $display("test_store_merge done");
    endtask

    task automatic test_same_cycle();
        start_fill(2'd0);
        storeValid = 1'b1; storeWordAddr = 3'd1; storeByteEn = 4'b1000; SDQ_mux = 32'hAB000000;
        beat({32'h55667788, 32'h11223344}, 1'b0);
        storeValid = 1'b0;
        n_cmp++; if (w1 !== 32'hAB223344) begin n_bad++; $display("FAIL same_word1 got=%h exp=ab223344", w1); end
        n_cmp++; if (fillBufWordValid !== 8'h03) begin n_bad++; $display("FAIL same_valid got=%h exp=03", fillBufWordValid); end
        storeValid = 1'b1; storeWordAddr = 3'd0; storeByteEn = 4'b0001; SDQ_mux = 32'h000000EE;
        step();
        storeValid = 1'b0;
        n_cmp++; if (w0 !== 32'h556677EE) begin n_bad++; $display("FAIL same_word0_late got=%h exp=556677ee", w0); end
        for (int k = 1; k < 4; k++) beat(64'h0, 1'b0);
        ack_line();
        step();
        $display("test_same_cycle done");
    endtask

    task automatic test_error();
        start_fill(2'd1);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (fillErr !== 1'b0) begin n_bad++; $display("FAIL err_early k=%0d got=%b exp=0", k, fillErr); end
            beat(64'hFFFF_FFFF_FFFF_FFFF, (k == 1));
        end
        n_cmp++; if (fillErr !== 1'b1) begin n_bad++; $display("FAIL err_pulse got=%b exp=1", fillErr); end
        n_cmp++; if ({arrayWrReq, fillBusy} !== 2'b00) begin n_bad++; $display("FAIL err_state got=%b exp=00", {arrayWrReq, fillBusy}); end
        n_cmp++; if (fillBufWordValid !== 8'h00) begin n_bad++; $display("FAIL err_valid got=%h exp=00", fillBufWordValid); end
        step();
        n_cmp++; if ({fillErr, arrayWrReq, fillDone} !== 3'b000) begin n_bad++; $display("FAIL err_after got=%b exp=000", {fillErr, arrayWrReq, fillDone}); end
        $display("test_error done");
    endtask

    task automatic test_ack_delay();
        start_fill(2'd3);
        for (int k = 0; k < 4; k++) beat({32'(32'h3000 + k), 32'(32'h4000 + k)}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({arrayWrReq, fillDone} !== 2'b10) begin n_bad++; $display("FAIL ack_hold i=%0d got=%b exp=10", i, {arrayWrReq, fillDone}); end
            if (i == 2) begin
                storeValid = 1'b1; storeWordAddr = 3'd0; storeByteEn = 4'b1111; SDQ_mux = 32'hDEADBEEF;
                #1;
                n_cmp++; if (storeStall !== 1'b1) begin n_bad++; $display("FAIL ack_stall got=%b exp=1", storeStall); end
            end
            if (i == 4) arrayWrAck = 1'b1;
            step();
            storeValid = 1'b0;
            n_cmp++; if (w0 !== 32'h3001) begin n_bad++; $display("FAIL ack_word0 i=%0d got=%h exp=00003001", i, w0); end
        end
        arrayWrAck = 1'b0;
        n_cmp++; if ({fillDone, arrayWrReq} !== 2'b10) begin n_bad++; $display("FAIL ack_done got=%b exp=10", {fillDone, arrayWrReq}); end
        step();
        n_cmp++; if (fillDone !== 1'b0) begin n_bad++; $display("FAIL ack_done_pulse got=%b exp=0", fillDone); end
        $display("test_ack_delay done");
    endtask

    task automatic test_reset_mid();
        start_fill(2'd0);
        beat({32'h0A0A0A0A, 32'h0B0B0B0B}, 1'b0);
        beat({32'h0C0C0C0C, 32'h0D0D0D0D}, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if ({fillBusy, fillDone, fillErr} !== 3'b000) begin n_bad++; $display("FAIL rmid_state got=%b exp=000", {fillBusy, fillDone, fillErr}); end
        n_cmp++; if (fillBufWordValid !== 8'h00) begin n_bad++; $display("FAIL rmid_valid got=%h exp=00", fillBufWordValid); end
        n_cmp++; if (w0 !== 32'h0) begin n_bad++; $display("FAIL rmid_word0 got=%h exp=00000000", w0); end
        step();
        n_cmp++; if ({fillDone, fillErr} !== 2'b00) begin n_bad++; $display("FAIL rmid_pulse got=%b exp=00", {fillDone, fillErr}); end
        start_fill(2'd0);
        for (int k = 0; k < 4; k++) beat({32'(32'h5000 + k), 32'(32'h6000 + k)}, 1'b0);
        n_cmp++; if (arrayWrReq !== 1'b1) begin n_bad++; $display("FAIL rmid_refill_req got=%b exp=1", arrayWrReq); end
        n_cmp++; if (w6 !== 32'h5003) begin n_bad++; $display("FAIL rmid_refill_word6 got=%h exp=00005003", w6); end
        ack_line();
        n_cmp++; if (fillDone !== 1'b1) begin n_bad++; $display("FAIL rmid_refill_done got=%b exp=1", fillDone); end
        step();
        $display("test_reset_mid done");
    endtask

    task automatic test_bypass();
        loadReq = 1'b1; loadWordAddr = 3'd5;
        #1;
        n_cmp++; if (loadHit !== 1'b0) begin n_bad++; $display("FAIL byp_idle_hit got=%b exp=0", loadHit); end
        plbRdDAck = 1'b1; plbRdData = 64'h1234_5678_9ABC_DEF0;
        step();
        plbRdDAck = 1'b0;
        n_cmp++; if ({fillBusy, fillBufWordValid} !== 9'h000) begin n_bad++; $display("FAIL byp_idle_beat got=%h exp=000", {fillBusy, fillBufWordValid}); end
        start_fill(2'd0);
        storeValid = 1'b1; storeWordAddr = 3'd5; storeByteEn = 4'b1111; SDQ_mux = 32'hCAFEF00D;
        #1;
        n_cmp++; if (bypassFillSDP_sel !== 4'b1111) begin n_bad++; $display("FAIL byp_sel got=%b exp=1111", bypassFillSDP_sel); end
        n_cmp++; if (loadHit !== 1'b1) begin n_bad++; $display("FAIL byp_hit got=%b exp=1", loadHit); end
        n_cmp++; if (bypassMuxSel !== 3'd5) begin n_bad++; $display("FAIL byp_muxsel got=%0d exp=5", bypassMuxSel); end
        storeByteEn = 4'b0011;
        #1;
        n_cmp++; if ({bypassFillSDP_sel, loadHit} !== 5'b00110) begin n_bad++; $display("FAIL byp_partial got=%b exp=00110", {bypassFillSDP_sel, loadHit}); end
        storeByteEn = 4'b1111;
        step();
        storeValid = 1'b0;
        n_cmp++; if ({w5, fillBufWordValid[5]} !== {32'hCAFEF00D, 1'b0}) begin n_bad++; $display("FAIL byp_word5 got=%h/%b exp=cafef00d/0", w5, fillBufWordValid[5]); end
        loadWordAddr = 3'd0;
        plbRdDAck = 1'b1; plbRdData = 64'h1111_1111_2222_2222;
        #1;
        n_cmp++; if (loadHit !== 1'b0) begin n_bad++; $display("FAIL byp_lat_before got=%b exp=0", loadHit); end
        step();
        plbRdDAck = 1'b0;
        n_cmp++; if (loadHit !== 1'b1) begin n_bad++; $display("FAIL byp_lat_after got=%b exp=1", loadHit); end
        fillStart = 1'b1; fillStartDw = 2'd3;
        step();
        fillStart = 1'b0;
        n_cmp++; if (fillBufWordValid !== 8'h03) begin n_bad++; $display("FAIL byp_restart_ignored got=%h exp=03", fillBufWordValid); end
        beat(64'h0, 1'b0);
        n_cmp++; if (fillBufWordValid !== 8'h0F) begin n_bad++; $display("FAIL byp_dw_keep got=%h exp=0f", fillBufWordValid); end
        loadReq = 1'b0;
        beat(64'h0, 1'b0);
        beat(64'h0, 1'b0);
        ack_line();
        step();
        $display("test_bypass done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fillStart = 1'b0; fillStartDw = 2'd0;
        plbRdDAck = 1'b0; plbRdData = 64'h0; plbRdErr = 1'b0;
        storeValid = 1'b0; storeWordAddr = 3'd0; storeByteEn = 4'h0; SDQ_mux = 32'h0;
        loadReq = 1'b0; loadWordAddr = 3'd0; arrayWrAck = 1'b0;
        test_reset();
        test_fill_order();
        test_store_merge();
        test_same_cycle();
        test_error();
        test_ack_delay();
        test_reset_mid();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
